// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage: ID/EX pipeline register feeding the ALU.
// Latches decoded operands, extends the immediate, selects operand b and
// resolves RAW hazards by forwarding from EX and WB.
// Build option: define FORWARDING_EN to include the forwarding muxes;
// without it the register file read data is used unchanged.
module id_ex_operand_stage #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned IMM_W      = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  id_valid,
  input  logic [2:0]            id_alu_control,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic [XLEN-1:0]       id_rs1_data,
  input  logic [XLEN-1:0]       id_rs2_data,
  input  logic [IMM_W-1:0]      id_imm,
  input  logic                  id_use_imm,
  input  logic                  id_reg_write,
  input  logic                  id_branch,
  input  logic [XLEN-1:0]       ex_result,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  wb_we,
  input  logic [XLEN-1:0]       wb_data,
  output logic [XLEN-1:0]       a,
  output logic [XLEN-1:0]       b,
  output logic [2:0]            alu_control,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  ex_reg_write,
  output logic                  ex_branch,
  output logic                  ex_valid
);

  localparam logic [2:0] ALU_SLL = 3'b011;

  logic [XLEN-1:0] fwd_a;
  logic [XLEN-1:0] fwd_b;
  logic [XLEN-1:0] b_sel;

`ifdef FORWARDING_EN
  logic ex_fwd_ok;
  logic wb_fwd_ok;

  // Forwarding sources are only live when they write a non-zero register
  assign ex_fwd_ok = ex_valid && ex_reg_write && (ex_rd != '0);
  assign wb_fwd_ok = wb_we && (wb_rd != '0);

  // Operand forwarding: EX has priority over WB, otherwise register file
  always_comb begin
    fwd_a = id_rs1_data;
    fwd_b = id_rs2_data;
    if (ex_fwd_ok && (ex_rd == id_rs1)) begin
      fwd_a = ex_result;
    end else if (wb_fwd_ok && (wb_rd == id_rs1)) begin
      fwd_a = wb_data;
    end
    if (ex_fwd_ok && (ex_rd == id_rs2)) begin
      fwd_b = ex_result;
    end else if (wb_fwd_ok && (wb_rd == id_rs2)) begin
      fwd_b = wb_data;
    end
  end
`else
  logic unused_fwd_inputs;

  // Forwarding inputs stay on the port list but carry no function here
  assign unused_fwd_inputs = ^{ex_result, wb_rd, wb_we, wb_data};

  // Operands come straight from the register file
  always_comb begin
    fwd_a = id_rs1_data;
    fwd_b = id_rs2_data;
  end
`endif

  // Operand b select: register, zero-extended shift amount, or sign-extended immediate
  always_comb begin
    b_sel = fwd_b;
    if (id_use_imm) begin
      if (id_alu_control == ALU_SLL) begin
        b_sel = XLEN'(id_imm[4:0]);
      end else begin
        b_sel = XLEN'($signed(id_imm));
      end
    end
  end

  // Stage register: reset > flush > stall > load (invalid decode loads a bubble)
  always_ff @(posedge clk) begin
    if (reset || flush || (!stall && !id_valid)) begin
      a            <= '0;
      b            <= '0;
      alu_control  <= '0;
      ex_rd        <= '0;
      ex_reg_write <= 1'b0;
      ex_branch    <= 1'b0;
      ex_valid     <= 1'b0;
    end else if (!stall) begin
      a            <= fwd_a;
      b            <= b_sel;
      alu_control  <= id_alu_control;
      ex_rd        <= id_rd;
      ex_reg_write <= id_reg_write;
      ex_branch    <= id_branch;
      ex_valid     <= 1'b1;
    end
  end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Self-checking bench for id_ex_operand_stage: directed steps then random
// traffic, compared against a behavioural model of the stage.
module tb_id_ex_operand_stage;

  logic        clk = 1'b0;
  logic        reset, stall, flush, id_valid;
  logic [2:0]  id_alu_control;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [31:0] id_rs1_data, id_rs2_data;
  logic [11:0] id_imm;
  logic        id_use_imm, id_reg_write, id_branch;
  logic [31:0] ex_result;
  logic [4:0]  wb_rd;
  logic        wb_we;
  logic [31:0] wb_data;
  logic [31:0] a, b;
  logic [2:0]  alu_control;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_branch, ex_valid;

  int checks = 0;
  int errors = 0;

  // Model of the stage outputs
  logic [31:0] m_a, m_b;
  logic [2:0]  m_ctl;
  logic [4:0]  m_rd;
  logic        m_rw, m_br, m_v;

  always #5 clk = ~clk;

  id_ex_operand_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_alu_control(id_alu_control), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_use_imm(id_use_imm), .id_reg_write(id_reg_write), .id_branch(id_branch),
    .ex_result(ex_result), .wb_rd(wb_rd), .wb_we(wb_we), .wb_data(wb_data),
    .a(a), .b(b), .alu_control(alu_control), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_branch(ex_branch), .ex_valid(ex_valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Value an operand read would see after forwarding
  function automatic logic [31:0] m_fwd(input logic [4:0] rs, input logic [31:0] d);
`ifdef FORWARDING_EN
    if (rs == 5'd0) return d;
    if (m_v && m_rw && m_rd == rs) return ex_result;
    if (wb_we && wb_rd == rs) return wb_data;
`endif
    return d;
  endfunction

  // Advance one clock: compute expected next state, clock the DUT, compare
  task automatic step();
    logic [31:0] na, nb;
    logic [2:0]  nctl;
    logic [4:0]  nrd;
    logic        nrw, nbr, nv;
    na = m_a; nb = m_b; nctl = m_ctl; nrd = m_rd; nrw = m_rw; nbr = m_br; nv = m_v;
    if (reset || flush || (!stall && !id_valid)) begin
      na = 0; nb = 0; nctl = 0; nrd = 0; nrw = 0; nbr = 0; nv = 0;
    end else if (!stall) begin
      na = m_fwd(id_rs1, id_rs1_data);
      if (!id_use_imm) nb = m_fwd(id_rs2, id_rs2_data);
      else if (id_alu_control == 3'b011) nb = {27'd0, id_imm[4:0]};
      else nb = {{20{id_imm[11]}}, id_imm};
      nctl = id_alu_control; nrd = id_rd; nrw = id_reg_write; nbr = id_branch; nv = 1;
    end
    @(posedge clk);
    #1;
    m_a = na; m_b = nb; m_ctl = nctl; m_rd = nrd; m_rw = nrw; m_br = nbr; m_v = nv;
    chk("a", a, m_a);
    chk("b", b, m_b);
    chk("alu_control", 32'(alu_control), 32'(m_ctl));
    chk("ex_rd", 32'(ex_rd), 32'(m_rd));
    chk("ex_reg_write", 32'(ex_reg_write), 32'(m_rw));
    chk("ex_branch", 32'(ex_branch), 32'(m_br));
    chk("ex_valid", 32'(ex_valid), 32'(m_v));
  endtask

  task automatic set_instr(input logic [2:0] ctl, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                           input logic [11:0] imm, input logic use_imm, input logic rw);
    id_valid = 1; id_alu_control = ctl; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_rs1_data = d1; id_rs2_data = d2; id_imm = imm; id_use_imm = use_imm;
    id_reg_write = rw; id_branch = (ctl == 3'b100);
  endtask

  function automatic logic [4:0] pick_reg();
    logic [4:0] r;
    case ($urandom_range(0, 4))
      0: r = 5'd0;
      1: r = 5'd1;
      2: r = 5'd5;
      3: r = 5'd7;
      default: r = 5'($urandom);
    endcase
    return r;
  endfunction

  initial begin
    logic [31:0] held_a, held_b;
    m_a = 0; m_b = 0; m_ctl = 0; m_rd = 0; m_rw = 0; m_br = 0; m_v = 0;
    stall = 0; flush = 0; ex_result = 0; wb_rd = 0; wb_we = 0; wb_data = 0;

    // Reset with a valid instruction presented
    reset = 1;
    set_instr(3'b000, 5'd1, 5'd2, 5'd3, 32'h3, 32'h2, 12'h0, 1'b0, 1'b1);
    step();
    chk("reset_a", a, 32'h0);
    chk("reset_ex_valid", 32'(ex_valid), 32'h0);
    reset = 0;

    // ADD
    step();
    chk("add_a", a, 32'h3);
    chk("add_b", b, 32'h2);
    chk("add_valid", 32'(ex_valid), 32'h1);

    // ANDI sign-extends, SLL zero-extends the shift amount
    set_instr(3'b010, 5'd1, 5'd2, 5'd3, 32'h3, 32'h2, 12'hFFF, 1'b1, 1'b1);
    step();
    chk("andi_b", b, 32'hFFFF_FFFF);
    set_instr(3'b011, 5'd1, 5'd2, 5'd3, 32'h3, 32'h2, 12'h7E2, 1'b1, 1'b1);
    step();
    chk("sll_b", b, 32'h2);

    // EX forwarding into operand a
    set_instr(3'b000, 5'd1, 5'd2, 5'd5, 32'h3, 32'h2, 12'h0, 1'b0, 1'b1);
    step();
    ex_result = 32'h5;
    set_instr(3'b000, 5'd5, 5'd2, 5'd5, 32'hDEAD, 32'h2, 12'h0, 1'b0, 1'b1);
    step();
`ifdef FORWARDING_EN
    chk("ex_fwd_a", a, 32'h5);
`else
    chk("ex_fwd_a", a, 32'hDEAD);
`endif

    // EX beats WB on the same register
    ex_result = 32'h5; wb_rd = 5'd5; wb_we = 1; wb_data = 32'h7;
    set_instr(3'b000, 5'd1, 5'd5, 5'd0, 32'h3, 32'h99, 12'h0, 1'b0, 1'b1);
    step();
`ifdef FORWARDING_EN
    chk("ex_over_wb_b", b, 32'h5);
`else
    chk("ex_over_wb_b", b, 32'h99);
`endif

    // Register 0 is never forwarded (ex_rd is now 0)
    ex_result = 32'h1234; wb_rd = 5'd0; wb_we = 1; wb_data = 32'h55;
    set_instr(3'b001, 5'd0, 5'd0, 5'd4, 32'h0, 32'h0, 12'h0, 1'b0, 1'b1);
    step();
    chk("r0_a", a, 32'h0);
    wb_we = 0;

    // Stall for three cycles while decode inputs change
    held_a = m_a; held_b = m_b;
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      set_instr(3'($urandom), pick_reg(), pick_reg(), pick_reg(), $urandom, $urandom,
                12'($urandom), 1'($urandom), 1'($urandom));
      step();
      chk("stall_a", a, held_a);
      chk("stall_b", b, held_b);
    end

    // Flush overrides stall
    flush = 1;
    step();
    chk("flush_valid", 32'(ex_valid), 32'h0);
    chk("flush_rw", 32'(ex_reg_write), 32'h0);
    chk("flush_a", a, 32'h0);
    stall = 0; flush = 0;

    // Invalid decode loads a bubble; reset during a stall still clears
    set_instr(3'b100, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 12'h0, 1'b0, 1'b0);
    step();
    id_valid = 0;
    step();
    chk("bubble_valid", 32'(ex_valid), 32'h0);
    set_instr(3'b000, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 12'h0, 1'b0, 1'b1);
    step();
    stall = 1; reset = 1;
    step();
    chk("reset_stall_valid", 32'(ex_valid), 32'h0);
    stall = 0; reset = 0;

    // Random traffic with frequent register collisions
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 49) == 0);
      flush = ($urandom_range(0, 15) == 0);
      stall = ($urandom_range(0, 7) == 0);
      set_instr(3'($urandom_range(0, 4)), pick_reg(), pick_reg(), pick_reg(), $urandom, $urandom,
                12'($urandom), 1'($urandom), 1'($urandom));
      id_valid = ($urandom_range(0, 7) != 0);
      ex_result = $urandom; wb_rd = pick_reg(); wb_we = 1'($urandom); wb_data = $urandom;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register that sits directly upstream of the ALU and drives its a, b and alu_control inputs.
- Latches decoded operands, sign- or zero-extends the immediate, and selects register or immediate for operand b.
- Resolves RAW hazards by forwarding from the instruction currently in EX and from writeback.
- Supports stall (hold) and flush (bubble) from the hazard/branch logic.

Parameters:
XLEN, 32, datapath width
REG_ADDR_W, 5, register index width
IMM_W, 12, raw immediate width from decode

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
stall  in  1  hold all stage registers
flush  in  1  load a bubble
id_valid  in  1  decode holds a real instruction
id_alu_control  in  3  000 ADD, 001 OR, 010 ANDI, 011 SLL, 100 SUB (BNE)
id_rs1  in  REG_ADDR_W  source 1 index
id_rs2  in  REG_ADDR_W  source 2 index
id_rd  in  REG_ADDR_W  destination index
id_rs1_data  in  XLEN  register file read port 1
id_rs2_data  in  XLEN  register file read port 2
id_imm  in  IMM_W  raw immediate
id_use_imm  in  1  b comes from the immediate
id_reg_write  in  1  instruction writes rd
id_branch  in  1  instruction is BNE
ex_result  in  XLEN  ALU result of the instruction now held in this stage
wb_rd  in  REG_ADDR_W  writeback destination
wb_we  in  1  writeback enable
wb_data  in  XLEN  writeback value
a  out  XLEN  ALU operand a
b  out  XLEN  ALU operand b
alu_control  out  3  ALU operation
ex_rd  out  REG_ADDR_W  registered rd
ex_reg_write  out  1  registered write enable, qualified by valid
ex_branch  out  1  registered branch flag, qualified by valid
ex_valid  out  1  stage holds a real instruction

Behaviour:
- Timing and reset
  - Clock is clk. Reset is synchronous and active-high on reset.
  - All outputs register on the rising edge of clk; latency is 1 cycle from the id_* inputs to the outputs.
- Update priority per edge: reset > flush > stall > load.
  - reset: every output becomes 0 (alu_control = 000, ex_valid = 0). Reset mid-stall or mid-flush still clears everything.
  - flush: a bubble is loaded: ex_valid, ex_reg_write, ex_branch, a, b, alu_control and ex_rd all become 0. flush overrides stall.
  - stall (without flush): all outputs hold their current values.
  - load with id_valid = 0: a bubble is loaded, same as flush.
  - load with id_valid = 1: ex_valid = 1; alu_control, ex_rd, ex_reg_write and ex_branch take the id_* values.
- Operand a = fwd(id_rs1, id_rs1_data).
- Operand b
  - id_use_imm = 0: b = fwd(id_rs2, id_rs2_data), full XLEN; the ALU uses b[4:0] for SLL.
  - id_use_imm = 1 and id_alu_control = 011: b = zero-extended id_imm[4:0].
  - id_use_imm = 1, any other operation: b = id_imm sign-extended to XLEN.
- fwd(rs, data), evaluated combinationally before the register:
  - ex_valid & ex_reg_write & ex_rd != 0 & ex_rd == rs -> ex_result.
  - else wb_we & wb_rd != 0 & wb_rd == rs -> wb_data.
  - else -> data.
  - EX wins over WB when both match. Register 0 is never forwarded.
- Width rules
  - No arithmetic is performed in this stage.
  - Sign extension replicates id_imm[IMM_W-1].
- No internal state other than the output registers; no FSM.
- id_branch instructions with id_reg_write = 0 are never forwarding sources.

Optional Feature:
- FORWARDING_EN
  - Defined: the forwarding muxes above are present.
  - Undefined: fwd(rs, data) = data. ex_result, wb_rd, wb_we and wb_data remain ports but are ignored. All other behaviour is identical.

Test Plan:
1. Reset: reset = 1, id_valid = 1, id_rs1_data = 0x3 -> after the edge, a = 0, b = 0, alu_control = 000, ex_valid = 0.
2. ADD: id_rs1_data = 0x3, id_rs2_data = 0x2, id_alu_control = 000, id_use_imm = 0 -> next cycle a = 0x3, b = 0x2, ex_valid = 1.
3. Immediates:
   - ANDI with id_imm = 0xFFF, id_use_imm = 1 -> b = 0xFFFFFFFF.
   - SLL with id_imm = 0x7E2 -> b = 0x00000002.
4. EX forwarding:
   - Instr1: rd = 5, reg_write = 1. Then ex_result = 0x5.
   - Instr2: rs1 = 5, id_rs1_data = 0xDEAD.
   - With FORWARDING_EN -> a = 0x5. Without it -> a = 0xDEAD.
5. Forwarding priority and register 0:
   - ex_rd = 5, ex_result = 0x5, wb_rd = 5, wb_data = 0x7, rs2 = 5 -> b = 0x5.
   - ex_rd = 0, wb_rd = 0, rs1 = 0, id_rs1_data = 0x0 -> a = 0x0.
6. Stall/flush:
   - stall = 1 for 3 cycles while the id_* inputs change -> outputs frozen.
   - stall = 1 with flush = 1 -> bubble: ex_valid = 0, ex_reg_write = 0, a = 0.
